// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the four-port SDRAM burst arbiter: port numbering,
// FSM encoding and small helpers used by the top level.
package sdram_arb_pkg;

  typedef logic [1:0] port_idx_t;

  localparam int NPORTS = 4;

  // Search order after reset follows the numbering: rd0, rd1, wr0, wr1.
  localparam port_idx_t PORT_RD0 = 2'd0;
  localparam port_idx_t PORT_RD1 = 2'd1;
  localparam port_idx_t PORT_WR0 = 2'd2;
  localparam port_idx_t PORT_WR1 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic logic port_is_rd(input port_idx_t p);
    return (p == PORT_RD0) || (p == PORT_RD1);
  endfunction

  // Mask bit within the read or write pair that the port owns.
  function automatic logic [1:0] port_mask(input port_idx_t p);
    return p[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command channel between the port arbiter and the single-burst SDRAM engine,
// plus the FIFO request masks that follow the granted port.
interface sdram_port_arbiter_if #(
  parameter int ASIZE = 23,
  parameter int LSIZE = 9
);
  logic             CMD_VALID;
  logic             CMD_RD;
  logic [ASIZE-1:0] CMD_ADDR;
  logic [LSIZE-1:0] CMD_LEN;
  logic             CMD_DONE;
  logic [1:0]       WR_MASK;
  logic [1:0]       RD_MASK;

  modport master (
    output CMD_VALID, CMD_RD, CMD_ADDR, CMD_LEN, WR_MASK, RD_MASK,
    input  CMD_DONE
  );

  modport slave (
    input  CMD_VALID, CMD_RD, CMD_ADDR, CMD_LEN, WR_MASK, RD_MASK,
    output CMD_DONE
  );
endinterface

// File: rtl/sdram_port_addr_gen.sv
// Rolling SDRAM address for one port: reload from start, advance by the
// burst length on completion, wrap to start once the next burst would reach max.
module sdram_port_addr_gen #(
  parameter int ASIZE = 23,
  parameter int LSIZE = 9
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [ASIZE-1:0] start_addr,
  input  logic [ASIZE-1:0] max_addr,
  input  logic [LSIZE-1:0] len,
  input  logic             load,
  input  logic             done,
  output logic [ASIZE-1:0] addr
);

  // One extra bit so addr + len cannot overflow before the compare.
  logic [ASIZE:0] addr_sum;

  assign addr_sum = {1'b0, addr} + (ASIZE+1)'(len);

  // Address register; a reload takes priority over a completing burst.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr <= '0;
    end else if (load) begin
      addr <= start_addr;
    end else if (done) begin
      if (addr_sum < {1'b0, max_addr}) addr <= addr_sum[ASIZE-1:0];
      else                             addr <= start_addr;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Four-port round-robin scheduler in front of the single-burst SDRAM engine.
// Ports 0/1 are read FIFOs (display), ports 2/3 are write FIFOs (ingest).
//
// state | meaning
// IDLE  | search for an eligible port, grant and latch the command
// BUSY  | command held stable until the engine pulses CMD_DONE
// GAP   | one dead cycle so the engine sees a fresh CMD_VALID edge
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ASIZE = 23,
  parameter int LSIZE = 9,
  parameter int USEDW = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [2*USEDW-1:0]   WR_USEDW,
  input  logic [2*USEDW-1:0]   RD_USEDW,
  input  logic [2*ASIZE-1:0]   WR_START,
  input  logic [2*ASIZE-1:0]   WR_MAX,
  input  logic [2*ASIZE-1:0]   RD_START,
  input  logic [2*ASIZE-1:0]   RD_MAX,
  input  logic [2*LSIZE-1:0]   WR_LEN,
  input  logic [2*LSIZE-1:0]   RD_LEN,
  input  logic [1:0]           WR_LOAD,
  input  logic [1:0]           RD_LOAD,
  sdram_port_arbiter_if.master cmd
);

  logic [ASIZE-1:0]  port_start [NPORTS];
  logic [ASIZE-1:0]  port_max   [NPORTS];
  logic [LSIZE-1:0]  port_len   [NPORTS];
  logic [ASIZE-1:0]  port_addr  [NPORTS];
  logic [NPORTS-1:0] port_load;
  logic [NPORTS-1:0] port_elig;
  logic [NPORTS-1:0] port_done;

  arb_state_t state, state_nxt;
  port_idx_t  rr_ptr;
  port_idx_t  grant_idx;
  port_idx_t  sel_idx;
  port_idx_t  cand_idx;
  logic       sel_found;
  logic       grant_en;
  logic       done_en;

  for (genvar i = 0; i < 2; i++) begin : g_map
    assign port_start[PORT_RD0+i] = RD_START[i*ASIZE +: ASIZE];
    assign port_start[PORT_WR0+i] = WR_START[i*ASIZE +: ASIZE];
    assign port_max[PORT_RD0+i]   = RD_MAX[i*ASIZE +: ASIZE];
    assign port_max[PORT_WR0+i]   = WR_MAX[i*ASIZE +: ASIZE];
    assign port_len[PORT_RD0+i]   = RD_LEN[i*LSIZE +: LSIZE];
    assign port_len[PORT_WR0+i]   = WR_LEN[i*LSIZE +: LSIZE];
    assign port_load[PORT_RD0+i]  = RD_LOAD[i];
    assign port_load[PORT_WR0+i]  = WR_LOAD[i];

    // A read FIFO needs room for a whole burst; a write FIFO needs a whole burst queued.
    assign port_elig[PORT_RD0+i] =
      (RD_USEDW[i*USEDW +: USEDW] < USEDW'(RD_LEN[i*LSIZE +: LSIZE])) &&
      (RD_LEN[i*LSIZE +: LSIZE] != '0) && !RD_LOAD[i];
    assign port_elig[PORT_WR0+i] =
      (WR_USEDW[i*USEDW +: USEDW] >= USEDW'(WR_LEN[i*LSIZE +: LSIZE])) &&
      (WR_LEN[i*LSIZE +: LSIZE] != '0) && !WR_LOAD[i];
  end

  // The advance uses the latched burst length, i.e. what the engine actually moved.
  for (genvar p = 0; p < NPORTS; p++) begin : g_addr
    assign port_done[p] = done_en && (grant_idx == port_idx_t'(p));

    sdram_port_addr_gen #(
      .ASIZE (ASIZE),
      .LSIZE (LSIZE)
    ) u_addr_gen (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .start_addr (port_start[p]),
      .max_addr   (port_max[p]),
      .len        (cmd.CMD_LEN),
      .load       (port_load[p]),
      .done       (port_done[p]),
      .addr       (port_addr[p])
    );
  end

  // Round-robin search: first eligible port at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand_idx  = rr_ptr;
    for (int k = 0; k < NPORTS; k++) begin
      cand_idx = rr_ptr + port_idx_t'(k);
      if (!sel_found && port_elig[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic; CMD_DONE outside BUSY is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = BUSY;
      BUSY:    if (cmd.CMD_DONE) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode into load/clear strobes for the command registers.
  always_comb begin
    grant_en = (state == IDLE) && sel_found;
    done_en  = (state == BUSY) && cmd.CMD_DONE;
  end

  // Registered command, masks and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd.CMD_VALID <= 1'b0;
      cmd.CMD_RD    <= 1'b0;
      cmd.CMD_ADDR  <= '0;
      cmd.CMD_LEN   <= '0;
      cmd.RD_MASK   <= 2'b00;
      cmd.WR_MASK   <= 2'b00;
      grant_idx     <= PORT_RD0;
      rr_ptr        <= PORT_RD0;
    end else if (grant_en) begin
      cmd.CMD_VALID <= 1'b1;
      cmd.CMD_RD    <= port_is_rd(sel_idx);
      cmd.CMD_ADDR  <= port_addr[sel_idx];
      cmd.CMD_LEN   <= port_len[sel_idx];
      cmd.RD_MASK   <= port_is_rd(sel_idx) ? port_mask(sel_idx) : 2'b00;
      cmd.WR_MASK   <= port_is_rd(sel_idx) ? 2'b00 : port_mask(sel_idx);
      grant_idx     <= sel_idx;
      rr_ptr        <= sel_idx + 2'd1;
    end else if (done_en) begin
      cmd.CMD_VALID <= 1'b0;
      cmd.RD_MASK   <= 2'b00;
      cmd.WR_MASK   <= 2'b00;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: acts as the SDRAM engine, drives FIFO
// levels and per-port configuration, and checks grants against hand-worked values.
module tb_sdram_port_arbiter;

  localparam int ASIZE = 23;
  localparam int LSIZE = 9;
  localparam int USEDW = 16;

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic [2*USEDW-1:0]   WR_USEDW = '0;
  logic [2*USEDW-1:0]   RD_USEDW = '0;
  logic [2*ASIZE-1:0]   WR_START = '0;
  logic [2*ASIZE-1:0]   WR_MAX = '0;
  logic [2*ASIZE-1:0]   RD_START = '0;
  logic [2*ASIZE-1:0]   RD_MAX = '0;
  logic [2*LSIZE-1:0]   WR_LEN = '0;
  logic [2*LSIZE-1:0]   RD_LEN = '0;
  logic [1:0]           WR_LOAD = '0;
  logic [1:0]           RD_LOAD = '0;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int waited;

  sdram_port_arbiter_if #(.ASIZE(ASIZE), .LSIZE(LSIZE)) cmd ();

  sdram_port_arbiter #(
    .ASIZE (ASIZE),
    .LSIZE (LSIZE),
    .USEDW (USEDW)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .WR_USEDW (WR_USEDW),
    .RD_USEDW (RD_USEDW),
    .WR_START (WR_START),
    .WR_MAX   (WR_MAX),
    .RD_START (RD_START),
    .RD_MAX   (RD_MAX),
    .WR_LEN   (WR_LEN),
    .RD_LEN   (RD_LEN),
    .WR_LOAD  (WR_LOAD),
    .RD_LOAD  (RD_LOAD),
    .cmd      (cmd.master)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a grant, check it, hold one cycle, then complete it.
  // On return the arbiter is one cycle into GAP; waited counts ticks until CMD_VALID.
  task automatic do_burst(input string tag, input logic exp_rd, input logic [31:0] exp_addr,
                          input logic [31:0] exp_len, input logic [1:0] exp_rm,
                          input logic [1:0] exp_wm, input logic load_rd0, output int n_wait);
    n_wait = 0;
    while (!cmd.CMD_VALID && n_wait < 10) begin
      tick();
      n_wait++;
    end
    chk({tag, "_valid"}, 32'(cmd.CMD_VALID), 32'd1);
    chk({tag, "_rd"},    32'(cmd.CMD_RD), 32'(exp_rd));
    chk({tag, "_addr"},  32'(cmd.CMD_ADDR), exp_addr);
    chk({tag, "_len"},   32'(cmd.CMD_LEN), exp_len);
    chk({tag, "_rmask"}, 32'(cmd.RD_MASK), 32'(exp_rm));
    chk({tag, "_wmask"}, 32'(cmd.WR_MASK), 32'(exp_wm));
    tick();
    chk({tag, "_hold_valid"}, 32'(cmd.CMD_VALID), 32'd1);
    chk({tag, "_hold_addr"},  32'(cmd.CMD_ADDR), exp_addr);
    cmd.CMD_DONE = 1'b1;
    if (load_rd0) RD_LOAD[0] = 1'b1;
    tick();
    cmd.CMD_DONE = 1'b0;
    RD_LOAD[0]   = 1'b0;
    chk({tag, "_gap_valid"}, 32'(cmd.CMD_VALID), 32'd0);
    chk({tag, "_gap_rmask"}, 32'(cmd.RD_MASK), 32'd0);
    chk({tag, "_gap_wmask"}, 32'(cmd.WR_MASK), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    cmd.CMD_DONE = 1'b0;

    // Reset values
    #3;
    chk("rst_valid", 32'(cmd.CMD_VALID), 32'd0);
    chk("rst_rd",    32'(cmd.CMD_RD), 32'd0);
    chk("rst_addr",  32'(cmd.CMD_ADDR), 32'd0);
    chk("rst_len",   32'(cmd.CMD_LEN), 32'd0);
    chk("rst_rmask", 32'(cmd.RD_MASK), 32'd0);
    chk("rst_wmask", 32'(cmd.WR_MASK), 32'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // rd0 alone: first burst at 0, then at 0x100, next grant 3 cycles after DONE
    RD_MAX[22:0]   = 23'h400;
    RD_LEN[8:0]    = 9'd256;
    RD_USEDW[15:0] = 16'd0;
    do_burst("s1a", 1'b1, 32'h0, 32'd256, 2'b01, 2'b00, 1'b0, waited);
    chk("s1a_latency", 32'(waited), 32'd1);
    do_burst("s1b", 1'b1, 32'h100, 32'd256, 2'b01, 2'b00, 1'b0, waited);
    chk("s1b_gap", 32'(waited), 32'd2);
    RD_USEDW[15:0] = 16'd300;

    // Wrap: start 0x100, max 0x400, len 0x100
    RD_START[22:0] = 23'h100;
    RD_LOAD[0] = 1'b1;
    tick();
    RD_LOAD[0] = 1'b0;
    RD_USEDW[15:0] = 16'd0;
    do_burst("s2a", 1'b1, 32'h100, 32'h100, 2'b01, 2'b00, 1'b0, waited);
    do_burst("s2b", 1'b1, 32'h200, 32'h100, 2'b01, 2'b00, 1'b0, waited);
    do_burst("s2c", 1'b1, 32'h300, 32'h100, 2'b01, 2'b00, 1'b0, waited);
    do_burst("s2d", 1'b1, 32'h100, 32'h100, 2'b01, 2'b00, 1'b0, waited);
    RD_USEDW[15:0] = 16'd300;

    // Write eligibility: wr1 has len 0, wr0 one word short of a burst
    WR_MAX          = {23'h7FFFFF, 23'h7FFFFF};
    WR_LEN[17:9]    = 9'd0;
    WR_USEDW[31:16] = 16'd500;
    WR_LEN[8:0]     = 9'd256;
    WR_USEDW[15:0]  = 16'd255;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s4_nogrant", 32'(cmd.CMD_VALID), 32'd0);
    end
    WR_USEDW[15:0] = 16'd256;
    do_burst("s4_wr0", 1'b0, 32'h0, 32'd256, 2'b00, 2'b01, 1'b0, waited);
    chk("s4_latency", 32'(waited), 32'd1);
    WR_USEDW[15:0] = 16'd0;

    // LOAD together with DONE on rd0 (addr was 0x200): reload wins
    RD_START[22:0] = 23'h40;
    RD_USEDW[15:0] = 16'd0;
    do_burst("s5a", 1'b1, 32'h200, 32'h100, 2'b01, 2'b00, 1'b1, waited);
    RD_USEDW[15:0] = 16'd300;
    tick();
    tick();
    // Stray DONE while idle must not move rd0's address
    cmd.CMD_DONE = 1'b1;
    tick();
    cmd.CMD_DONE = 1'b0;
    tick();
    chk("s5_idle_valid", 32'(cmd.CMD_VALID), 32'd0);
    chk("s5_idle_rmask", 32'(cmd.RD_MASK), 32'd0);
    RD_USEDW[15:0] = 16'd0;
    do_burst("s5b", 1'b1, 32'h40, 32'h100, 2'b01, 2'b00, 1'b0, waited);

    // All four eligible; pointer now at rd1, so rd1 is granted first
    RD_LEN[17:9]    = 9'd16;
    RD_USEDW[31:16] = 16'd0;
    RD_MAX[45:23]   = 23'h7FFFFF;
    WR_USEDW[15:0]  = 16'd300;
    WR_LEN[17:9]    = 9'd64;
    waited = 0;
    while (!cmd.CMD_VALID && waited < 10) begin
      tick();
      waited++;
    end
    chk("s6_pre_valid", 32'(cmd.CMD_VALID), 32'd1);
    chk("s6_pre_rmask", 32'(cmd.RD_MASK), 32'b10);

    // Asynchronous reset mid-burst
    RESET_N = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(cmd.CMD_VALID), 32'd0);
    chk("s6_rst_rmask", 32'(cmd.RD_MASK), 32'd0);
    chk("s6_rst_wmask", 32'(cmd.WR_MASK), 32'd0);
    tick();
    RESET_N = 1'b1;

    // Round-robin from rd0 with all addresses back at 0
    do_burst("rr0", 1'b1, 32'h0,   32'd256, 2'b01, 2'b00, 1'b0, waited);
    do_burst("rr1", 1'b1, 32'h0,   32'd16,  2'b10, 2'b00, 1'b0, waited);
    chk("rr1_gap", 32'(waited), 32'd2);
    do_burst("rr2", 1'b0, 32'h0,   32'd256, 2'b00, 2'b01, 1'b0, waited);
    chk("rr2_gap", 32'(waited), 32'd2);
    do_burst("rr3", 1'b0, 32'h0,   32'd64,  2'b00, 2'b10, 1'b0, waited);
    chk("rr3_gap", 32'(waited), 32'd2);
    do_burst("rr4", 1'b1, 32'h100, 32'd256, 2'b01, 2'b00, 1'b0, waited);
    chk("rr4_gap", 32'(waited), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
